// File: rtl/bcd_to_binary_if.sv
// Handshake/data bundle for the BCD-to-binary converter.
// master: the requester (drives start/bcd_in); slave: the converter.
// Handshake: start is sampled on a rising clk edge only while busy=0;
// the edge that samples start=1 also captures bcd_in. done is a one-cycle
// pulse marking bin_out/ovf/err valid; those hold until the next done.
interface bcd_to_binary_if;
  logic        start;
  logic [19:0] bcd_in;
  logic        busy;
  logic        done;
  logic [15:0] bin_out;
  logic        ovf;
  logic        err;

  modport master (
    output start,
    output bcd_in,
    input  busy,
    input  done,
    input  bin_out,
    input  ovf,
    input  err
  );

  modport slave (
    input  start,
    input  bcd_in,
    output busy,
    output done,
    output bin_out,
    output ovf,
    output err
  );
endinterface

// File: rtl/bcd_to_binary.sv
// Sequential 5-digit packed BCD to 16-bit binary converter using
// reverse double-dabble, one bit per clock (17 iterations).
// Optional macro BCD_TO_BINARY_DIGIT_CHECK_EN: flags nibbles > 9 at accept
// and reports err=1 with bin_out/ovf forced to 0 at done.
module bcd_to_binary (
  input  logic                 clk,
  input  logic                 rst_n,
  bcd_to_binary_if.slave       bus,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Last iteration index: counter runs 0..16 for 17 shifts.
  localparam logic [4:0] LAST_ITER = 5'd16;

  state_t      state_q;
  logic [36:0] work_q;
  logic [36:0] work_d;
  logic [36:0] shifted;
  logic [4:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] bin_q;
  logic        ovf_q;

`ifdef BCD_TO_BINARY_DIGIT_CHECK_EN
  logic        inv_q;
  logic        err_q;
  logic        bad_digit;

  // Any input nibble above 9 marks the operand as invalid BCD.
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus.bcd_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end
`endif

  // One reverse double-dabble step: shift right, then correct every BCD
  // nibble in the upper 20 bits (>= 8 -> -3). The binary half is untouched.
  always_comb begin
    shifted = {1'b0, work_q[36:1]};
    work_d  = shifted;
    for (int i = 0; i < 5; i++) begin
      if (shifted[17 + 4*i +: 4] >= 4'd8) begin
        work_d[17 + 4*i +: 4] = shifted[17 + 4*i +: 4] - 4'd3;
      end
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bin_q   <= '0;
      ovf_q   <= 1'b0;
`ifdef BCD_TO_BINARY_DIGIT_CHECK_EN
      inv_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            work_q  <= {bus.bcd_in, 17'b0};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_SHIFT;
`ifdef BCD_TO_BINARY_DIGIT_CHECK_EN
            inv_q   <= bad_digit;
`endif
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_SHIFT: begin
          work_q <= work_d;
          cnt_q  <= cnt_q + 5'd1;
          if (cnt_q == LAST_ITER) begin
            // Result is taken from this final step's output, not work_q.
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
`ifdef BCD_TO_BINARY_DIGIT_CHECK_EN
            err_q   <= inv_q;
            bin_q   <= inv_q ? 16'h0000 : work_d[15:0];
            ovf_q   <= inv_q ? 1'b0 : work_d[16];
`else
            bin_q   <= work_d[15:0];
            ovf_q   <= work_d[16];
`endif
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.bin_out = bin_q;
  assign bus.ovf     = ovf_q;
`ifdef BCD_TO_BINARY_DIGIT_CHECK_EN
  assign bus.err     = err_q;
`else
  assign bus.err     = 1'b0;
`endif
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary: directed vector table, hand-written
// multi-cycle sequences and randomized valid-BCD operands against a
// decimal-arithmetic reference model.
module tb_bcd_to_binary;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  bcd_to_binary_if bus ();

  bcd_to_binary dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [17:0] exp_q[$];   // {err, ovf, bin}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: decimal value of the digits, plain arithmetic.
  function automatic logic [17:0] ref_model(input logic [19:0] b);
    int unsigned v;
    bit bad;
    logic [3:0] d;
    logic [31:0] vv;
    v = 0;
    bad = 1'b0;
    for (int i = 4; i >= 0; i--) begin
      d = b[4*i +: 4];
      if (d > 4'd9) bad = 1'b1;
      v = v * 10 + int'(d);
    end
    vv = v;
`ifdef BCD_TO_BINARY_DIGIT_CHECK_EN
    if (bad) return {1'b1, 1'b0, 16'h0000};
`endif
    return {1'b0, (v > 65535), vv[15:0]};
  endfunction

  // ---------------- driver ----------------
  // Starts a conversion, waits for done (bounded), compares with exp_q head.
  // Returns at #1 after the done edge (inside the DONE cycle).
  task automatic run_conv(input logic [19:0] b, input string name, input bit chk_val);
    int lat;
    logic [17:0] e;
    bus.start  = 1'b1;
    bus.bcd_in = b;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.bcd_in = 20'($urandom);
    check({name, "_accept_busy"}, bus.busy, 1);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    check({name, "_latency"}, lat, 17);
    check({name, "_busy_at_done"}, bus.busy, 0);
    if (exp_q.size() == 0) begin
      check({name, "_scoreboard_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check({name, "_err"}, bus.err, e[17]);
      if (chk_val) begin
        check({name, "_bin"}, bus.bin_out, e[15:0]);
        check({name, "_ovf"}, bus.ovf, e[16]);
      end
    end
  endtask

  typedef struct {
    logic [19:0] bcd;
    logic [15:0] bin;
    logic        ovf;
    logic        err;
    bit          chk_val;
  } vec_t;

  vec_t vecs[9];
  logic [1:0] idle_code;

  initial begin
    int ndone;
    bit saw_busy;
    logic [15:0] first_bin;
    logic [19:0] rb;

    vecs[0] = '{20'h12345, 16'h3039, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{20'h65535, 16'hFFFF, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{20'h99999, 16'h869F, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{20'h00000, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{20'h00009, 16'h0009, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{20'h65536, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{20'h10000, 16'h2710, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{20'h00100, 16'h0064, 1'b0, 1'b0, 1'b1};
`ifdef BCD_TO_BINARY_DIGIT_CHECK_EN
    vecs[8] = '{20'h1A234, 16'h0000, 1'b0, 1'b1, 1'b1};
`else
    vecs[8] = '{20'h1A234, 16'h0000, 1'b0, 1'b0, 1'b0};
`endif

    // Reset, then idle with no start.
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.bcd_in = 20'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_bin", bus.bin_out, 0);
    check("rst_ovf", bus.ovf, 0);
    check("rst_err", bus.err, 0);
    idle_code = dbg_state;
    @(negedge clk);
    rst_n = 1'b1;
    saw_busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.busy || bus.done) saw_busy = 1'b1;
    end
    check("idle_no_activity", saw_busy, 0);
    check("idle_bin", bus.bin_out, 0);

    // Directed table.
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back({vecs[i].err, vecs[i].ovf, vecs[i].bin});
      run_conv(vecs[i].bcd, $sformatf("vec%0d", i), vecs[i].chk_val);
      @(posedge clk); #1;
      check($sformatf("vec%0d_done_pulse", i), bus.done, 0);
    end

    // Back-to-back: second start issued during the DONE cycle.
    exp_q.push_back(ref_model(20'h65535));
    run_conv(20'h65535, "b2b_first", 1'b1);
    exp_q.push_back(ref_model(20'h99999));
    run_conv(20'h99999, "b2b_second", 1'b1);
    @(posedge clk); #1;
    check("b2b_done_fall", bus.done, 0);

    // start pulsed while busy must be ignored.
    bus.start  = 1'b1;
    bus.bcd_in = 20'h00009;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.start  = 1'b1;
    bus.bcd_in = 20'h12345;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    ndone = 0;
    first_bin = 16'hDEAD;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        if (ndone == 0) first_bin = bus.bin_out;
        ndone++;
      end
    end
    check("ignore_done_count", ndone, 1);
    check("ignore_bin", first_bin, 16'h0009);

    // Reset in the middle of a conversion.
    bus.start  = 1'b1;
    bus.bcd_in = 20'h12345;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_bin", bus.bin_out, 0);
    check("midrst_ovf", bus.ovf, 0);
    check("midrst_state", dbg_state, idle_code);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) ndone++;
    end
    check("midrst_no_done", ndone, 0);
    exp_q.push_back(ref_model(20'h00042));
    run_conv(20'h00042, "after_rst", 1'b1);

    // Randomized valid BCD operands against the reference model.
    for (int n = 0; n < 25; n++) begin
      rb = '0;
      for (int d = 0; d < 5; d++) rb[4*d +: 4] = 4'($urandom_range(0, 9));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      exp_q.push_back(ref_model(rb));
      run_conv(rb, $sformatf("rnd%0d_%05h", n, rb), 1'b1);
    end

    repeat (2) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
